// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port seen by mem_arbiter.
// The master modport is the arbiter; the slave modport is the clients plus the memory.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ack;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata;
  logic        m_ready;

  logic        bus_error;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ready,
    output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, m_be, bus_error
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ready,
    input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, m_be, bus_error
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory port, data-first with a fetch
// starvation guard and a per-access wait timeout that terminates with bus_error.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus_io
);
  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  state_e            state_q;
  logic [1:0]        streak_q, streak_d;
  logic [WAIT_W-1:0] wait_q;
  logic              m_req_q, m_we_q;
  logic [31:0]       m_addr_q, m_wdata_q;
  logic [3:0]        m_be_q;
  logic              i_ack_q, d_ack_q, bus_err_q;
  logic [31:0]       i_rdata_q, d_rdata_q;

  logic              i_elig, d_elig, grant_fetch, grant_data;

  // A port acked this cycle is still holding its old request, so it sits out.
  always_comb begin
    i_elig      = bus_io.i_req & ~i_ack_q;
    d_elig      = bus_io.d_req & ~d_ack_q;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    if (state_q == IDLE) begin
      if (d_elig && !(i_elig && streak_q[1])) grant_data = 1'b1;
      else if (i_elig)                        grant_fetch = 1'b1;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (grant_fetch)
      streak_d = 2'd0;
    else if (grant_data)
      streak_d = bus_io.i_req ? ((streak_q == 2'd3) ? 2'd3 : streak_q + 2'd1) : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      wait_q    <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      bus_err_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      bus_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          streak_q <= streak_d;
          if (grant_data) begin
            state_q   <= BUSY_D;
            m_req_q   <= 1'b1;
            m_we_q    <= bus_io.d_we;
            m_addr_q  <= bus_io.d_addr;
            m_wdata_q <= bus_io.d_wdata;
            m_be_q    <= bus_io.d_be;
            wait_q    <= '0;
          end else if (grant_fetch) begin
            state_q  <= BUSY_I;
            m_req_q  <= 1'b1;
            m_we_q   <= 1'b0;
            m_addr_q <= bus_io.i_addr;
            m_be_q   <= 4'b1111;
            wait_q   <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus_io.m_ready || (wait_q == WAIT_LAST)) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            bus_err_q <= ~bus_io.m_ready;
            if (state_q == BUSY_I) begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= bus_io.m_ready ? bus_io.m_rdata : 32'h0;
            end else begin
              d_ack_q <= 1'b1;
              // Stores leave the load-data register untouched unless they time out.
              if (!bus_io.m_ready)  d_rdata_q <= 32'h0;
              else if (!m_we_q)     d_rdata_q <= bus_io.m_rdata;
            end
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.m_req     = m_req_q;
  assign bus_io.m_we      = m_we_q;
  assign bus_io.m_addr    = m_addr_q;
  assign bus_io.m_wdata   = m_wdata_q;
  assign bus_io.m_be      = m_be_q;
  assign bus_io.i_ack     = i_ack_q;
  assign bus_io.i_rdata   = i_rdata_q;
  assign bus_io.d_ack     = d_ack_q;
  assign bus_io.d_rdata   = d_rdata_q;
  assign bus_io.bus_error = bus_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: grants and acks are predicted when stimulus
// is issued and checked in order by a negedge monitor; scenario tasks add inline checks.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  mem_arbiter #(.TIMEOUT(16)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } grant_t;

  typedef struct {
    logic        is_d;
    logic        err;
    logic [31:0] rdata;
  } ack_t;

  grant_t gq[$];
  ack_t   aq[$];
  grant_t mg;
  ack_t   ma;
  int     n_vec  = 0;
  int     n_miss = 0;
  bit     mem_en = 1'b1;
  logic   mreq_prev = 1'b0;
  logic [31:0] mdl_i_rdata, mdl_d_rdata, mdl_wdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h00A00093;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Advance one cycle; the memory answers in the same cycle m_req is seen, if enabled.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.m_ready = (bus.m_req === 1'b1) && mem_en;
    bus.m_rdata = (bus.m_req === 1'b1) ? mem_word(bus.m_addr) : 32'hBAD0_BAD0;
  endtask

  task automatic exp_fetch(input logic [31:0] a, input bit err);
    grant_t g;
    ack_t   k;
    g.we = 1'b0; g.addr = a; g.wdata = mdl_wdata; g.be = 4'hF;
    gq.push_back(g);
    k.is_d = 1'b0; k.err = err; k.rdata = err ? 32'h0 : mem_word(a);
    mdl_i_rdata = k.rdata;
    aq.push_back(k);
  endtask

  task automatic exp_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input bit err, input bit has_ack);
    grant_t g;
    ack_t   k;
    g.we = we; g.addr = a; g.wdata = wd; g.be = be;
    gq.push_back(g);
    mdl_wdata = wd;
    if (has_ack) begin
      k.is_d  = 1'b1;
      k.err   = err;
      k.rdata = err ? 32'h0 : (we ? mdl_d_rdata : mem_word(a));
      mdl_d_rdata = k.rdata;
      aq.push_back(k);
    end
  endtask

  task automatic data_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be);
    exp_data(we, a, wd, be, 1'b0, 1'b1);
    bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_be = be; bus.d_req = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (bus.d_ack === 1'b1) break;
    end
    n_vec++;
    if (bus.d_ack !== 1'b1) begin
      n_miss++;
      $display("FAIL data_ack_wait: d_ack=%b after 20 cycles, required 1 (addr=%h)", bus.d_ack, a);
    end
    bus.d_req = 1'b0;
  endtask

  // Scoreboard monitor: each new grant and each ack is matched against the next prediction.
  always @(negedge clk) begin
    if (bus.m_req === 1'b1 && mreq_prev !== 1'b1) begin
      n_vec++;
      if (gq.size() == 0) begin
        n_miss++;
        $display("FAIL grant_unexpected: got addr=%h we=%b, required no grant", bus.m_addr, bus.m_we);
      end else begin
        mg = gq.pop_front();
        if ({bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata} !== {mg.we, mg.be, mg.addr, mg.wdata}) begin
          n_miss++;
          $display("FAIL grant: got we=%b be=%h addr=%h wdata=%h, required we=%b be=%h addr=%h wdata=%h",
                   bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata, mg.we, mg.be, mg.addr, mg.wdata);
        end
      end
    end
    mreq_prev = bus.m_req;
    if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
      n_vec++;
      if (aq.size() == 0) begin
        n_miss++;
        $display("FAIL ack_unexpected: got i_ack=%b d_ack=%b, required none", bus.i_ack, bus.d_ack);
      end else begin
        ma = aq.pop_front();
        if ({bus.i_ack, bus.d_ack, bus.bus_error, (ma.is_d ? bus.d_rdata : bus.i_rdata)} !==
            {~ma.is_d, ma.is_d, ma.err, ma.rdata}) begin
          n_miss++;
          $display("FAIL ack: got i_ack=%b d_ack=%b err=%b rdata=%h, required i_ack=%b d_ack=%b err=%b rdata=%h",
                   bus.i_ack, bus.d_ack, bus.bus_error, (ma.is_d ? bus.d_rdata : bus.i_rdata),
                   ~ma.is_d, ma.is_d, ma.err, ma.rdata);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h1234; bus.d_req = 1'b1; bus.d_we = 1'b1;
    bus.d_addr = 32'h5678; bus.d_wdata = 32'hFFFF_FFFF; bus.d_be = 4'hF;
    tick(); tick();
    n_vec++;
    if ({bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_be, bus.i_ack, bus.d_ack,
         bus.i_rdata, bus.d_rdata, bus.bus_error} !== 138'h0) begin
      n_miss++;
      $display("FAIL reset_outputs: got m_req=%b m_addr=%h m_wdata=%h i_rdata=%h d_rdata=%h, required all 0",
               bus.m_req, bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata);
    end
    tick();
    n_vec++;
    if (bus.m_req !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_mreq_held: got %b, required 0", bus.m_req);
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0; rst_n = 1'b1;
    mdl_i_rdata = '0; mdl_d_rdata = '0; mdl_wdata = '0;
    tick();
    n_vec++;
    if (bus.m_req !== 1'b0) begin
      n_miss++;
      $display("FAIL idle_no_req: got m_req=%b, required 0", bus.m_req);
    end
  endtask

  task automatic test_single_fetch();
    exp_fetch(32'h100, 1'b0);
    bus.i_addr = 32'h100; bus.i_req = 1'b1;
    tick();
    n_vec++;
    if ({bus.m_req, bus.m_we, bus.m_be, bus.m_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      n_miss++;
      $display("FAIL fetch_cycle1: got m_req=%b m_we=%b m_be=%h m_addr=%h, required 1 0 f 00000100",
               bus.m_req, bus.m_we, bus.m_be, bus.m_addr);
    end
    tick();
    n_vec++;
    if ({bus.i_ack, bus.i_rdata} !== {1'b1, 32'h00A00093}) begin
      n_miss++;
      $display("FAIL fetch_ack: got i_ack=%b i_rdata=%h, required 1 00a00093", bus.i_ack, bus.i_rdata);
    end
    bus.i_req = 1'b0;
    tick();
    n_vec++;
    if ({bus.i_ack, bus.m_req} !== 2'b00) begin
      n_miss++;
      $display("FAIL fetch_ack_pulse: got i_ack=%b m_req=%b, required 0 0", bus.i_ack, bus.m_req);
    end
  endtask

  task automatic test_collision();
    exp_data(1'b1, 32'h200, 32'hDEADBEEF, 4'h1, 1'b0, 1'b1);
    exp_fetch(32'h180, 1'b0);
    bus.i_addr = 32'h180; bus.i_req = 1'b1;
    bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'h1; bus.d_req = 1'b1;
    tick();
    n_vec++;
    if ({bus.m_req, bus.m_we, bus.m_be, bus.m_wdata, bus.m_addr} !== {1'b1, 1'b1, 4'h1, 32'hDEADBEEF, 32'h200}) begin
      n_miss++;
      $display("FAIL collision_data_first: got we=%b be=%h wdata=%h addr=%h, required 1 1 deadbeef 00000200",
               bus.m_we, bus.m_be, bus.m_wdata, bus.m_addr);
    end
    tick();
    n_vec++;
    if ({bus.d_ack, bus.i_ack} !== 2'b10) begin
      n_miss++;
      $display("FAIL collision_d_ack: got d_ack=%b i_ack=%b, required 1 0", bus.d_ack, bus.i_ack);
    end
    bus.d_req = 1'b0;
    tick();
    n_vec++;
    if ({bus.m_req, bus.m_we, bus.m_addr} !== {1'b1, 1'b0, 32'h180}) begin
      n_miss++;
      $display("FAIL collision_fetch_next: got m_req=%b we=%b addr=%h, required 1 0 00000180",
               bus.m_req, bus.m_we, bus.m_addr);
    end
    tick();
    bus.i_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] lw;
    lw = mem_word(32'h240);
    exp_data(1'b0, 32'h240, 32'h0, 4'hF, 1'b0, 1'b1);
    exp_data(1'b0, 32'h240, 32'h0, 4'hF, 1'b0, 1'b1);
    bus.d_we = 1'b0; bus.d_addr = 32'h240; bus.d_wdata = 32'h0; bus.d_be = 4'hF; bus.d_req = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({bus.d_ack, bus.m_req} !== 2'b10) begin
      n_miss++;
      $display("FAIL b2b_first_ack: got d_ack=%b m_req=%b, required 1 0", bus.d_ack, bus.m_req);
    end
    tick();
    n_vec++;
    if (bus.m_req !== 1'b0) begin
      n_miss++;
      $display("FAIL b2b_ack_cycle_ineligible: got m_req=%b, required 0", bus.m_req);
    end
    tick();
    n_vec++;
    if (bus.m_req !== 1'b1) begin
      n_miss++;
      $display("FAIL b2b_regrant: got m_req=%b, required 1", bus.m_req);
    end
    tick();
    bus.d_req = 1'b0;
    data_access(1'b1, 32'h244, 32'h12345678, 4'hC);
    n_vec++;
    if (bus.d_rdata !== lw) begin
      n_miss++;
      $display("FAIL store_keeps_rdata: got d_rdata=%h, required %h", bus.d_rdata, lw);
    end
    tick();
    n_vec++;
    if ({bus.m_req, bus.m_addr, bus.m_we, bus.m_be, bus.m_wdata} !== {1'b0, 32'h244, 1'b1, 4'hC, 32'h12345678}) begin
      n_miss++;
      $display("FAIL idle_hold: got m_req=%b addr=%h we=%b be=%h wdata=%h, required 0 00000244 1 c 12345678",
               bus.m_req, bus.m_addr, bus.m_we, bus.m_be, bus.m_wdata);
    end
  endtask

  task automatic test_starvation();
    int   grants;
    bit   done;
    logic prev;
    for (int r = 0; r < 2; r++) begin
      exp_data(1'b0, 32'h300, 32'h0BADF00D, 4'hF, 1'b0, 1'b1);
      exp_data(1'b0, 32'h300, 32'h0BADF00D, 4'hF, 1'b0, 1'b1);
      exp_fetch(32'h400, 1'b0);
    end
    bus.d_we = 1'b0; bus.d_addr = 32'h300; bus.d_wdata = 32'h0BADF00D; bus.d_be = 4'hF;
    bus.i_addr = 32'h400;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    grants = 0; done = 1'b0; prev = 1'b0;
    // Fetch steps back in each d_ack cycle so data can win twice in a row.
    for (int n = 0; n < 80 && !done; n++) begin
      tick();
      if (bus.m_req === 1'b1 && prev !== 1'b1) grants++;
      prev = bus.m_req;
      if (grants < 6) begin
        bus.i_req = ~bus.d_ack;
        bus.d_req = ~bus.d_ack;
      end else begin
        bus.d_req = 1'b0;
        if (bus.i_ack === 1'b1) begin
          bus.i_req = 1'b0;
          done = 1'b1;
        end
      end
    end
    n_vec++;
    if (!done) begin
      n_miss++;
      $display("FAIL starvation_complete: got %0d grants without final i_ack, required 6 and i_ack", grants);
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int first, ack_cyc;
    exp_data(1'b0, 32'h500, 32'h0, 4'hF, 1'b1, 1'b1);
    mem_en = 1'b0;
    bus.d_we = 1'b0; bus.d_addr = 32'h500; bus.d_wdata = 32'h0; bus.d_be = 4'hF; bus.d_req = 1'b1;
    first = -1; ack_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus.m_req === 1'b1 && first < 0) first = c;
      if (bus.d_ack === 1'b1) begin
        ack_cyc = c;
        break;
      end
    end
    n_vec++;
    if (first != 1 || ack_cyc - first != 16) begin
      n_miss++;
      $display("FAIL timeout_latency: got m_req cycle %0d ack cycle %0d, required 1 and 17", first, ack_cyc);
    end
    n_vec++;
    if ({bus.d_ack, bus.bus_error, bus.d_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      n_miss++;
      $display("FAIL timeout_ack: got d_ack=%b bus_error=%b d_rdata=%h, required 1 1 00000000",
               bus.d_ack, bus.bus_error, bus.d_rdata);
    end
    bus.d_req = 1'b0;
    mem_en = 1'b1;
    tick();
    n_vec++;
    if ({bus.bus_error, bus.d_ack} !== 2'b00) begin
      n_miss++;
      $display("FAIL timeout_pulse: got bus_error=%b d_ack=%b, required 0 0", bus.bus_error, bus.d_ack);
    end
  endtask

  task automatic test_reset_mid();
    bit stray;
    data_access(1'b0, 32'h540, 32'h0, 4'hF);
    tick();
    exp_data(1'b0, 32'h580, 32'h77, 4'hF, 1'b0, 1'b0);
    mem_en = 1'b0;
    bus.d_we = 1'b0; bus.d_addr = 32'h580; bus.d_wdata = 32'h77; bus.d_be = 4'hF; bus.d_req = 1'b1;
    tick(); tick(); tick();
    n_vec++;
    if (bus.m_req !== 1'b1) begin
      n_miss++;
      $display("FAIL busy_before_reset: got m_req=%b, required 1", bus.m_req);
    end
    rst_n = 1'b0; bus.d_req = 1'b0;
    tick();
    rst_n = 1'b1;
    mem_en = 1'b1;
    mdl_i_rdata = '0; mdl_d_rdata = '0; mdl_wdata = '0;
    n_vec++;
    if ({bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_be, bus.i_ack, bus.d_ack,
         bus.i_rdata, bus.d_rdata, bus.bus_error} !== 138'h0) begin
      n_miss++;
      $display("FAIL reset_mid_outputs: got m_req=%b m_addr=%h m_wdata=%h i_rdata=%h d_rdata=%h, required all 0",
               bus.m_req, bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata);
    end
    stray = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (bus.d_ack !== 1'b0 || bus.bus_error !== 1'b0 || bus.m_req !== 1'b0) stray = 1'b1;
    end
    n_vec++;
    if (stray) begin
      n_miss++;
      $display("FAIL reset_mid_quiet: got activity after abort, required no d_ack/bus_error/m_req");
    end
    exp_fetch(32'h600, 1'b0);
    bus.i_addr = 32'h600; bus.i_req = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (bus.i_ack === 1'b1) break;
    end
    n_vec++;
    if ({bus.i_ack, bus.i_rdata} !== {1'b1, mem_word(32'h600)}) begin
      n_miss++;
      $display("FAIL fetch_after_reset: got i_ack=%b i_rdata=%h, required 1 %h",
               bus.i_ack, bus.i_rdata, mem_word(32'h600));
    end
    bus.i_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0; bus.m_ready = 1'b0; bus.m_rdata = '0;
    mdl_i_rdata = '0; mdl_d_rdata = '0; mdl_wdata = '0;
    test_reset();
    test_single_fetch();
    test_collision();
    test_back_to_back();
    test_starvation();
    test_timeout();
    test_reset_mid();
    tick();
    n_vec++;
    if (gq.size() != 0 || aq.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d grants and %0d acks outstanding, required 0 and 0",
               gq.size(), aq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
